fc_layer_sequencer: RTL and testbench

Sequences one shared signed multiply-accumulate datapath over a fully connected layer of N_IN inputs by N_OUT outputs. The block fetches inputs, weights and biases from synchronous single-read-port memories and computes each output neuron serially. Results are written to an output buffer as saturated Q8.8 logits. It sits between the flatten stage (input buffer) and the argmax/classifier stage, and is kicked by the top-level inference controller with a start/done handshake.

---
 rtl/fc_pkg.sv | 38 +++
 rtl/fc_layer_sequencer_if.sv | 42 ++++
 rtl/fc_mac.sv | 46 ++++
 rtl/fc_layer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants, FSM state type and Q8.8 saturation helper
// Contents:
//   DW, FRAC, ACC_W   default datapath widths (Q8.8 words, 40-bit accumulator)
//   fc_state_t        layer sequencer FSM states
//   sat_q88()         ACC_W accumulator -> DW word: arithmetic shift by FRAC, then clamp
package fc_pkg;

  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;

  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN = -Q_MAX - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS,
    ST_MAC,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } fc_state_t;

  // The accumulator holds Q(2*FRAC) values; shifting right by FRAC returns to
  // Q8.8. The arithmetic shift floors toward negative infinity.
  function automatic logic [DW-1:0] sat_q88(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC;
    if (sh > Q_MAX) begin
      return {1'b0, {(DW-1){1'b1}}};
    end else if (sh < Q_MIN) begin
      return {1'b1, {(DW-1){1'b0}}};
    end else begin
      return sh[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// rtl/fc_layer_sequencer_if.sv - control and memory-port bundle of the FC layer sequencer
// Signals:
//   start/busy/done                 kick-off handshake with the inference controller
//   in_addr/in_data                 input buffer read port (1-cycle latency)
//   w_addr/w_data                   weight memory read port, row-major j*N_OUT+i
//   b_addr/b_data                   bias memory read port
//   out_we/out_addr/out_data        output buffer write port
// Modports: master = sequencer side, slave = controller/memory side.
interface fc_layer_sequencer_if #(
  parameter int N_IN  = 128,
  parameter int N_OUT = 10,
  parameter int DW    = 16
);

  localparam int IA_W = $clog2(N_IN);
  localparam int WA_W = $clog2(N_IN * N_OUT);
  localparam int BA_W = $clog2(N_OUT);

  logic            start;
  logic            busy;
  logic            done;
  logic [IA_W-1:0] in_addr;
  logic [DW-1:0]   in_data;
  logic [WA_W-1:0] w_addr;
  logic [DW-1:0]   w_data;
  logic [BA_W-1:0] b_addr;
  logic [DW-1:0]   b_data;
  logic            out_we;
  logic [BA_W-1:0] out_addr;
  logic [DW-1:0]   out_data;

  modport master (
    input  start, in_data, w_data, b_data,
    output busy, done, in_addr, w_addr, b_addr, out_we, out_addr, out_data
  );

  modport slave (
    output start, in_data, w_data, b_data,
    input  busy, done, in_addr, w_addr, b_addr, out_we, out_addr, out_data
  );

endinterface

// File: rtl/fc_mac.sv
// rtl/fc_mac.sv - registered signed multiply-accumulate for one output neuron
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         zero the accumulator
//   load_bias     acc <= sign_extend(bias) << FRAC
//   acc_en        acc <= acc + a*b (full 2*DW signed product)
//   a, b, bias    signed Q8.8 operands
//   acc           ACC_W signed accumulator
module fc_mac #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load_bias,
  input  logic                    acc_en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  input  logic signed [DW-1:0]    bias,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  // Bias is aligned to the Q(2*FRAC) scale of the products.
  assign bias_ext = {{(ACC_W-DW){bias[DW-1]}}, bias};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load_bias) begin
      acc <= bias_ext <<< FRAC;
    end else if (acc_en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - serial fully connected layer over one shared MAC
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        fc_layer_sequencer_if.master: start/busy/done handshake,
//              input/weight/bias read ports, output write port
// Each neuron takes BIAS + N_IN MAC + DRAIN + WRITE cycles. Memory data lags
// its address by one cycle, so MAC cycle k adds the product fetched at k-1 and
// DRAIN adds the last one.
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int N_IN  = 128,
  parameter int N_OUT = 10,
  parameter int DW    = fc_pkg::DW,
  parameter int FRAC  = fc_pkg::FRAC,
  parameter int ACC_W = fc_pkg::ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  fc_layer_sequencer_if.master bus
);

  localparam int IA_W = $clog2(N_IN);
  localparam int WA_W = $clog2(N_IN * N_OUT);
  localparam int BA_W = $clog2(N_OUT);

  fc_state_t state, state_next;

  logic [IA_W-1:0] k;
  logic [BA_W-1:0] i;
  logic [WA_W-1:0] w_addr;
  logic [BA_W-1:0] b_addr;
  logic            last_k;
  logic            last_i;

  logic clear;
  logic load_bias;
  logic acc_en;
  logic out_we;
  logic done;
  logic signed [ACC_W-1:0] acc;

  assign last_k = (k == IA_W'(N_IN - 1));
  assign last_i = (i == BA_W'(N_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    load_bias  = 1'b0;
    acc_en     = 1'b0;
    out_we     = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_BIAS;
          clear      = 1'b1;
        end
      end
      ST_BIAS: begin
        state_next = ST_MAC;
      end
      ST_MAC: begin
        // b_data (addressed in BIAS) is valid in the k=0 cycle.
        if (k == '0) begin
          load_bias = 1'b1;
        end else begin
          acc_en = 1'b1;
        end
        if (last_k) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        acc_en     = 1'b1;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        out_we     = 1'b1;
        state_next = last_i ? ST_DONE : ST_BIAS;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Counters double as registered addresses so every address holds its
  // last value while not in use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i      <= '0;
      k      <= '0;
      w_addr <= '0;
      b_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            i      <= '0;
            b_addr <= '0;
          end
        end
        ST_BIAS: begin
          k      <= '0;
          w_addr <= WA_W'(i);
        end
        ST_MAC: begin
          if (!last_k) begin
            k      <= k + 1'b1;
            w_addr <= w_addr + WA_W'(N_OUT);
          end
        end
        ST_WRITE: begin
          if (!last_i) begin
            i      <= i + 1'b1;
            b_addr <= i + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  fc_mac #(
    .DW   (DW),
    .FRAC (FRAC),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load_bias(load_bias),
    .acc_en   (acc_en),
    .a        (bus.in_data),
    .b        (bus.w_data),
    .bias     (bus.b_data),
    .acc      (acc)
  );

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done;
  assign bus.out_we   = out_we;
  assign bus.in_addr  = k;
  assign bus.w_addr   = w_addr;
  assign bus.b_addr   = b_addr;
  assign bus.out_addr = i;
  assign bus.out_data = sat_q88(acc);

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - self-checking bench for fc_layer_sequencer
module tb_fc_layer_sequencer;

  localparam int N_IN  = 128;
  localparam int N_OUT = 10;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;
  localparam int NEUR  = N_IN + 3;
  localparam int LAT   = N_OUT * NEUR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fc_layer_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus ();

  fc_layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] in_mem [N_IN];
  logic [15:0] w_mem  [N_IN*N_OUT];
  logic [15:0] b_mem  [N_OUT];
  logic [15:0] exp_v  [N_OUT];

  always @(posedge clk) begin
    bus.in_data <= in_mem[bus.in_addr];
    bus.w_data  <= w_mem[bus.w_addr];
    bus.b_data  <= b_mem[bus.b_addr];
  end

  int cnt = 0;
  int c0  = 0;
  always @(posedge clk) cnt <= cnt + 1;

  int          wr_addr_q [$];
  int          wr_cyc_q  [$];
  logic [15:0] wr_data_q [$];
  int          done_q    [$];

  always @(negedge clk) begin
    if (bus.out_we === 1'b1) begin
      wr_addr_q.push_back(int'(bus.out_addr));
      wr_data_q.push_back(bus.out_data);
      wr_cyc_q.push_back(cnt - c0);
    end
    if (bus.done === 1'b1) done_q.push_back(cnt - c0);
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: dot product in plain 64-bit arithmetic, floor division by 2^FRAC, clamp.
  task automatic compute_exp();
    for (int o = 0; o < N_OUT; o++) begin
      longint acc;
      acc = longint'($signed(b_mem[o])) * 256;
      for (int j = 0; j < N_IN; j++)
        acc += longint'($signed(in_mem[j])) * longint'($signed(w_mem[j*N_OUT + o]));
      acc = acc >>> FRAC;
      if (acc > 32767)       exp_v[o] = 16'h7FFF;
      else if (acc < -32768) exp_v[o] = 16'h8000;
      else                   exp_v[o] = acc[15:0];
    end
  endtask

  task automatic fill(input int mode);
    for (int j = 0; j < N_IN; j++) begin
      int r;
      r = int'($urandom_range(0, 1023)) - 512;
      case (mode)
        0:       in_mem[j] = 16'($urandom);
        1, 2, 3: in_mem[j] = 16'h0100;
        default: in_mem[j] = r[15:0];
      endcase
      for (int o = 0; o < N_OUT; o++) begin
        int s;
        s = int'($urandom_range(0, 511)) - 256;
        case (mode)
          0:       w_mem[j*N_OUT + o] = 16'($urandom);
          1:       w_mem[j*N_OUT + o] = (o == 3) ? 16'h0100 : 16'h0000;
          2, 3:    w_mem[j*N_OUT + o] = 16'hFF00;
          5:       w_mem[j*N_OUT + o] = 16'h0000;
          default: w_mem[j*N_OUT + o] = s[15:0];
        endcase
      end
    end
    for (int o = 0; o < N_OUT; o++) begin
      case (mode)
        0, 4:    b_mem[o] = 16'($urandom);
        1, 2:    b_mem[o] = 16'h0000;
        3:       b_mem[o] = 16'hFF00;
        default: b_mem[o] = 16'(o * 256);
      endcase
    end
    compute_exp();
  endtask

  task automatic launch();
    @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); done_q.delete();
    bus.start = 1'b1;
    c0 = cnt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_q.size() == 0 && t < LAT + 50) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done_seen"}, 64'(done_q.size() != 0), 64'd1);
    @(negedge clk);
  endtask

  task automatic verify(input string name);
    check({name, "_n_done"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) check({name, "_done_cyc"}, 64'(done_q[0]), 64'(LAT + 1));
    check({name, "_n_writes"}, 64'(wr_addr_q.size()), 64'(N_OUT));
    for (int o = 0; o < N_OUT && o < wr_addr_q.size(); o++) begin
      check($sformatf("%s_addr%0d", name, o), 64'(wr_addr_q[o]), 64'(o));
      check($sformatf("%s_data%0d", name, o), 64'(wr_data_q[o]), 64'(exp_v[o]));
      check($sformatf("%s_cyc%0d", name, o), 64'(wr_cyc_q[o]), 64'((o + 1) * NEUR));
    end
  endtask

  task automatic run_pass(input string name, input int mode);
    fill(mode);
    launch();
    wait_done(name);
    verify(name);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},     64'(bus.busy),     64'd0);
    check({name, "_done"},     64'(bus.done),     64'd0);
    check({name, "_out_we"},   64'(bus.out_we),   64'd0);
    check({name, "_in_addr"},  64'(bus.in_addr),  64'd0);
    check({name, "_w_addr"},   64'(bus.w_addr),   64'd0);
    check({name, "_b_addr"},   64'(bus.b_addr),   64'd0);
    check({name, "_out_addr"}, 64'(bus.out_addr), 64'd0);
    check({name, "_out_data"}, 64'(bus.out_data), 64'd0);
  endtask

  initial begin
    int t;
    int rise;
    bus.start = 1'b0;
    fill(5);

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Zero weights, bias ramp; a stray start at cycle 50 must be ignored, and
    // start held from the DONE cycle must begin a fresh pass.
    fill(5);
    launch();
    repeat (49) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while ((cnt - c0) != LAT + 1 && t < LAT + 50) begin
      @(negedge clk);
      t++;
    end
    check("ramp_done_pulse", 64'(bus.done), 64'd1);
    bus.start = 1'b1;
    @(negedge clk);
    verify("ramp");
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); done_q.delete();
    rise = cnt - c0;
    t = 0;
    while (bus.busy !== 1'b1 && t < 5) begin
      @(negedge clk);
      t++;
      rise = cnt - c0;
    end
    check("restart_busy", 64'(bus.busy), 64'd1);
    check("restart_latency", 64'(rise >= LAT + 2 && rise <= LAT + 3), 64'd1);
    bus.start = 1'b0;
    c0 = cnt - 1;
    wait_done("ramp2");
    verify("ramp2");

    run_pass("col3", 1);
    run_pass("neg", 2);
    run_pass("negb", 3);
    run_pass("rnd_full", 0);
    run_pass("rnd_small_a", 4);
    run_pass("rnd_small_b", 4);

    // Abort mid-pass at cycle 400: three writes already issued, nothing after.
    fill(4);
    launch();
    repeat (399) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 20) @(negedge clk);
    check("abort_n_writes", 64'(wr_addr_q.size()), 64'd3);
    check("abort_n_done", 64'(done_q.size()), 64'd0);
    check("abort_idle", 64'(bus.busy), 64'd0);

    run_pass("after_abort", 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
